mouse_tracker: RTL and testbench
================================

# mouse_tracker

Front-end conditioner for the pointing device. It synchronises raw quadrature and button pins, decodes X-axis quadrature into single steps, and accumulates a saturating 16-bit position. It debounces the active-low button. Its mouse_x and mouse_pressed_ outputs feed the counter logic of funny_module directly, sharing the same clock and reset_.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a button change; legal range ≥1.
- X_MAX, default 639: upper saturation bound of mouse_x; legal range 0..65535.

Ports:
- clock  input  1  system clock, all state on its rising edge.
- reset_  input  1  asynchronous, active-low reset.
- quad_a  input  1  raw X quadrature phase A, asynchronous to clock.
- quad_b  input  1  raw X quadrature phase B, asynchronous to clock.
- button_  input  1  raw button, active-low, bouncy, asynchronous.
- mouse_x  output  16  registered position, unsigned, 0..X_MAX.
- mouse_pressed_  output  1  debounced button, active-low (0 = pressed).
- mouse_moved  output  1  one-cycle pulse whenever mouse_x changes value.
- quad_error  output  1  one-cycle pulse on an illegal quadrature transition (both phases changed).

## Operation
- Reset (reset_ = 0, takes effect immediately, no clock needed):
  - mouse_x = 0, mouse_pressed_ = 1, mouse_moved = 0, quad_error = 0.
  - Synchronisers and previous-phase register = 00; button synchroniser = 1.
  - Debounce counter = 0; warm-up counter = 0.
- Synchronisation: each raw input passes through 2 flops (s1, s2); only s2 values are used downstream.
- Warm-up: for the first 3 rising edges after reset_ deasserts, the previous-phase register loads {a_s2, b_s2}, but no step, mouse_moved or quad_error is generated. This prevents a spurious step or error when the pins are not at 00 on release.
- Quadrature decode compares prev = {a,b} with cur = {a_s2,b_s2}:
  - Forward (+1): 00→01, 01→11, 11→10, 10→00.
  - Reverse (−1): the exact reverse of the forward sequence.
  - prev == cur: no action.
  - Both bits differ: quad_error pulses and mouse_x is unchanged.
  - prev loads cur every cycle.
- Accumulation:
  - +1 when mouse_x < X_MAX, otherwise hold.
  - −1 when mouse_x > 0, otherwise hold.
  - No wrap-around ever.
  - mouse_moved = 1 exactly on cycles where mouse_x is updated to a different value; a step blocked by saturation gives no pulse.
- Debounce (counter width sufficient for DEBOUNCE_CYCLES−1):
  - If btn_s2 == mouse_pressed_: counter clears.
  - Else if counter == DEBOUNCE_CYCLES−1: mouse_pressed_ loads btn_s2 and the counter clears.
  - Else: counter increments.
  - Any cycle of agreement restarts the count.
- Position and button paths are independent; simultaneous events on both are processed in the same cycle.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Quadrature latency: a pin change sampled at edge N → s2 valid after N+1 → mouse_x, mouse_moved and quad_error update at edge N+2.
- Maximum step rate is one per cycle; pins must hold each phase state ≥2 cycles for guaranteed decoding. Faster input is out of spec and may produce quad_error.
- Button latency: a change sampled at edge N and held → mouse_pressed_ updates at edge N+1+DEBOUNCE_CYCLES (N+5 at default).
- Reset asserted mid-step or mid-debounce discards all in-flight state.
- Reset deassertion must meet recovery/removal timing against clock; the warm-up window then applies.

## Test plan
- Reset: hold reset_=0 with pins at 11/0, toggle clock → mouse_x=0, mouse_pressed_=1, mouse_moved=0, quad_error=0. Release reset_ with pins at 11 → no step and no quad_error during or after warm-up.
- Forward/reverse: drive 00,01,11,10,00, each held 3 cycles → mouse_x reaches 4 with four single-cycle mouse_moved pulses, each 2 edges after sampling. Drive the reverse sequence → back to 0.
- Saturation (X_MAX=3): drive 6 forward steps → mouse_x stops at 3 with exactly 3 mouse_moved pulses. Then from 0, one reverse step → mouse_x stays 0 with no pulse.
- Illegal transition: from pin state 00 jump to 11 → one quad_error pulse at N+2, mouse_x unchanged, no mouse_moved. The next legal step decodes normally.
- Debounce (DEBOUNCE_CYCLES=4):
  - button_ low for 3 cycles, then high → mouse_pressed_ stays 1.
  - Low held → mouse_pressed_=0 at edge N+5.
  - High glitch of 2 cycles while pressed → no release.
- Async reset mid-operation: mouse_x=2 and debounce count in progress, pulse reset_=0 between edges → outputs return to reset values before the next edge. A subsequent 4-step forward sequence yields mouse_x=4.

Source files
------------

// File: rtl/mouse_tracker.sv
// Pointing-device front end: input synchronisers, X quadrature decode into a
// saturating position, and button debouncing. All outputs are registered.
module mouse_tracker #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned X_MAX           = 639
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        quad_a,
  input  logic        quad_b,
  input  logic        button_,
  output logic [15:0] mouse_x,
  output logic        mouse_pressed_,
  output logic        mouse_moved,
  output logic        quad_error
);

  localparam int unsigned CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]   XMAX    = 16'(X_MAX);

  typedef enum logic [1:0] {WARM0, WARM1, WARM2, RUN} warm_e;

  warm_e         warm_q, warm_d;
  logic          a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic          btn_s1_q, btn_s2_q;
  logic [1:0]    prev_q;
  logic [15:0]   x_q, x_d;
  logic          moved_q, moved_d;
  logic          err_q, err_d;
  logic          pressed_q, pressed_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0] cur;
  logic       fwd, rev, bad;

  assign cur = {a_s2_q, b_s2_q};

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      a_s1_q    <= 1'b0;
      a_s2_q    <= 1'b0;
      b_s1_q    <= 1'b0;
      b_s2_q    <= 1'b0;
      btn_s1_q  <= 1'b1;
      btn_s2_q  <= 1'b1;
      prev_q    <= '0;
      warm_q    <= WARM0;
      x_q       <= '0;
      moved_q   <= 1'b0;
      err_q     <= 1'b0;
      pressed_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      a_s1_q    <= quad_a;
      a_s2_q    <= a_s1_q;
      b_s1_q    <= quad_b;
      b_s2_q    <= b_s1_q;
      btn_s1_q  <= button_;
      btn_s2_q  <= btn_s1_q;
      prev_q    <= cur;
      warm_q    <= warm_d;
      x_q       <= x_d;
      moved_q   <= moved_d;
      err_q     <= err_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    bad = 1'b0;
    case ({prev_q, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: rev = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
      default: ;
    endcase
  end

  // Decode is suppressed until the synchronisers and prev_q hold real pin values.
  always_comb begin
    warm_d  = warm_q;
    x_d     = x_q;
    moved_d = 1'b0;
    err_d   = 1'b0;
    case (warm_q)
      WARM0:   warm_d = WARM1;
      WARM1:   warm_d = WARM2;
      WARM2:   warm_d = RUN;
      default: begin
        warm_d = RUN;
        if (fwd && (x_q < XMAX)) begin
          x_d     = x_q + 16'd1;
          moved_d = 1'b1;
        end else if (rev && (x_q != 16'd0)) begin
          x_d     = x_q - 16'd1;
          moved_d = 1'b1;
        end else if (bad) begin
          err_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    pressed_d = pressed_q;
    cnt_d     = cnt_q;
    if (btn_s2_q == pressed_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      pressed_d = btn_s2_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign mouse_x        = x_q;
  assign mouse_pressed_ = pressed_q;
  assign mouse_moved    = moved_q;
  assign quad_error     = err_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Scoreboard bench for mouse_tracker: drivers predict events into queues,
// a negedge monitor pops and compares whenever the DUT reports an event.
module tb_mouse_tracker;

  localparam int DEB = 4;
  localparam int XM  = 5;

  logic        clock = 1'b0;
  logic        reset_;
  logic        quad_a, quad_b, button_;
  logic [15:0] mouse_x;
  logic        mouse_pressed_, mouse_moved, quad_error;

  mouse_tracker #(.DEBOUNCE_CYCLES(DEB), .X_MAX(XM)) dut (
    .clock(clock), .reset_(reset_), .quad_a(quad_a), .quad_b(quad_b),
    .button_(button_), .mouse_x(mouse_x), .mouse_pressed_(mouse_pressed_),
    .mouse_moved(mouse_moved), .quad_error(quad_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; int x; bit mv; bit er; } qev_t;
  typedef struct { int cyc; bit p; } bev_t;
  qev_t qq[$];
  bev_t bq[$];

  int         errors = 0;
  int         checks = 0;
  int         model_x = 0;
  bit         model_p = 1'b1;
  logic [1:0] pins_m = 2'b11;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Position of a phase state along the forward Gray cycle 00,01,11,10.
  function automatic int gpos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Called just after a negedge; the change is sampled at the next posedge.
  task automatic quad_drive(input logic [1:0] s, input int hold);
    int   d;
    int   k;
    qev_t e;
    k = cyc;
    d = (gpos(s) - gpos(pins_m)) & 3;
    if (d == 1 && model_x < XM) begin
      model_x++;
      e = '{k + 3, model_x, 1'b1, 1'b0};
      qq.push_back(e);
    end else if (d == 3 && model_x > 0) begin
      model_x--;
      e = '{k + 3, model_x, 1'b1, 1'b0};
      qq.push_back(e);
    end else if (d == 2) begin
      e = '{k + 3, model_x, 1'b0, 1'b1};
      qq.push_back(e);
    end
    pins_m = s;
    {quad_a, quad_b} = s;
    repeat (hold) @(negedge clock);
  endtask

  // A level held for len samples is accepted once it differs for DEB samples.
  task automatic btn_drive(input logic lvl, input int len);
    int   k;
    bev_t e;
    k = cyc;
    if (lvl != model_p && len >= DEB) begin
      e = '{k + DEB + 2, lvl};
      bq.push_back(e);
      model_p = lvl;
    end
    button_ = lvl;
    repeat (len) @(negedge clock);
  endtask

  logic prev_p = 1'b1;
  qev_t me;
  bev_t mb;

  always @(negedge clock) begin
    if (!reset_) begin
      prev_p = 1'b1;
    end else begin
      while (qq.size() > 0 && qq[0].cyc < cyc) begin
        checks++; errors++;
        me = qq.pop_front();
        $display("FAIL quad_missing: no event seen, expected x=%0d at cycle %0d", me.x, me.cyc);
      end
      while (bq.size() > 0 && bq[0].cyc < cyc) begin
        checks++; errors++;
        mb = bq.pop_front();
        $display("FAIL button_missing: no change seen, expected %0d at cycle %0d", mb.p, mb.cyc);
      end
      if (mouse_moved || quad_error) begin
        if (qq.size() == 0) begin
          checks++; errors++;
          $display("FAIL quad_unexpected: moved=%0d err=%0d x=%0d, expected no event (cycle %0d)",
                   mouse_moved, quad_error, mouse_x, cyc);
        end else begin
          me = qq.pop_front();
          chk("quad_cycle", cyc, me.cyc);
          chk("quad_x", int'(mouse_x), me.x);
          chk("quad_moved", int'(mouse_moved), int'(me.mv));
          chk("quad_err", int'(quad_error), int'(me.er));
        end
      end
      if (mouse_pressed_ != prev_p) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL button_unexpected: pressed_=%0d, expected no change (cycle %0d)",
                   mouse_pressed_, cyc);
        end else begin
          mb = bq.pop_front();
          chk("button_cycle", cyc, mb.cyc);
          chk("button_level", int'(mouse_pressed_), int'(mb.p));
        end
        prev_p = mouse_pressed_;
      end
    end
  end

  logic [1:0] seq [0:22] = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11,
                             2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11,
                             2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11};
  logic [1:0] fwd4 [0:3] = '{2'b10, 2'b00, 2'b01, 2'b11};

  initial begin
    reset_ = 1'b0;
    {quad_a, quad_b} = 2'b11;
    button_ = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_x", int'(mouse_x), 0);
    chk("reset_pressed", int'(mouse_pressed_), 1);
    chk("reset_moved", int'(mouse_moved), 0);
    chk("reset_err", int'(quad_error), 0);
    button_ = 1'b1;
    @(negedge clock);
    reset_ = 1'b1;
    repeat (6) @(negedge clock);
    chk("warmup_x", int'(mouse_x), 0);

    // Blocked reverse at 0, full forward/reverse cycle, saturation, illegal jump.
    for (int i = 0; i < 23; i++) quad_drive(seq[i], 3);
    chk("directed_x", int'(mouse_x), 2);

    btn_drive(1'b0, 3);
    btn_drive(1'b1, 3);
    chk("short_press_ignored", int'(mouse_pressed_), 1);
    btn_drive(1'b0, 8);
    chk("press_accepted", int'(mouse_pressed_), 0);
    btn_drive(1'b1, 2);
    btn_drive(1'b0, 6);
    chk("glitch_ignored", int'(mouse_pressed_), 0);

    // Release in progress when reset hits between edges.
    button_ = 1'b1;
    repeat (2) @(negedge clock);
    chk("pre_reset_x", int'(mouse_x), 2);
    @(posedge clock);
    #2 reset_ = 1'b0;
    #1;
    chk("async_x", int'(mouse_x), 0);
    chk("async_pressed", int'(mouse_pressed_), 1);
    chk("async_moved", int'(mouse_moved), 0);
    chk("async_err", int'(quad_error), 0);
    qq.delete();
    bq.delete();
    model_x = 0;
    model_p = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset_ = 1'b1;
    repeat (5) @(negedge clock);
    for (int i = 0; i < 4; i++) quad_drive(fwd4[i], 3);
    chk("after_reset_x", int'(mouse_x), 4);

    fork
      begin
        logic [1:0] s;
        repeat (60) begin
          do s = 2'($urandom_range(0, 3)); while (s == pins_m);
          quad_drive(s, int'($urandom_range(2, 4)));
        end
      end
      begin
        repeat (30) btn_drive(!button_, int'($urandom_range(1, 8)));
      end
    join

    repeat (15) @(negedge clock);
    chk("quad_queue_drained", qq.size(), 0);
    chk("button_queue_drained", bq.size(), 0);
    chk("final_x", int'(mouse_x), model_x);
    chk("final_pressed", int'(mouse_pressed_), int'(model_p));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
